// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives a single-outstanding-request instruction memory and
// loads the IF/ID register, with hold buffering for stalls and squashing on redirect/flush.
module fetch_unit #(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_data,
  output logic [DATA_W-1:0] if_instr,
  output logic [ADDR_W-1:0] if_pc_next,
  output logic              if_valid
);

  typedef enum logic [1:0] {StIdle, StReq, StKill, StHold} state_e;

  state_e            state;
  logic              req;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] req_addr;
  logic [ADDR_W-1:0] req_inc;
  logic [DATA_W-1:0] buf_instr;
  logic [ADDR_W-1:0] buf_pcn;

  // Wraps modulo 2^ADDR_W by construction.
  assign req_inc   = req_addr + ADDR_W'(1);
  assign imem_req  = req;
  assign imem_addr = req_addr;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= StIdle;
      req        <= 1'b0;
      pc         <= '0;
      req_addr   <= '0;
      buf_instr  <= '0;
      buf_pcn    <= '0;
      if_instr   <= '0;
      if_pc_next <= '0;
      if_valid   <= 1'b0;
    end else begin
      case (state)
        StIdle: begin
          state    <= StReq;
          req      <= 1'b1;
          req_addr <= pc;
        end

        StReq: begin
          if (redirect) begin
            if_valid <= 1'b0;
            pc       <= redirect_addr;
            if (imem_ack) begin
              req_addr <= redirect_addr;
            end else begin
              state <= StKill;
            end
          end else if (flush) begin
            if_valid <= 1'b0;
            if (imem_ack) begin
              pc       <= req_inc;
              req_addr <= req_inc;
            end
          end else if (stall) begin
            if (imem_ack) begin
              buf_instr <= imem_data;
              buf_pcn   <= req_inc;
              pc        <= req_inc;
              req       <= 1'b0;
              state     <= StHold;
            end
          end else if (imem_ack) begin
            if_instr   <= imem_data;
            if_pc_next <= req_inc;
            if_valid   <= 1'b1;
            pc         <= req_inc;
            req_addr   <= req_inc;
          end else begin
            if_valid <= 1'b0;
          end
        end

        StKill: begin
          // The stale request must complete before the new target can be issued.
          if (redirect) pc <= redirect_addr;
          if (redirect || flush || !stall) if_valid <= 1'b0;
          if (imem_ack) begin
            state    <= StReq;
            req_addr <= redirect ? redirect_addr : pc;
          end
        end

        StHold: begin
          if (redirect) begin
            if_valid <= 1'b0;
            pc       <= redirect_addr;
            req_addr <= redirect_addr;
            req      <= 1'b1;
            state    <= StReq;
          end else if (flush) begin
            if_valid <= 1'b0;
            req_addr <= pc;
            req      <= 1'b1;
            state    <= StReq;
          end else if (!stall) begin
            if_instr   <= buf_instr;
            if_pc_next <= buf_pcn;
            if_valid   <= 1'b1;
            req_addr   <= pc;
            req        <= 1'b1;
            state      <= StReq;
          end
        end

        default: begin
          state <= StIdle;
          req   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter ADDR_W, default 11, SHALL set the instruction address width.
REQ-002 Parameter DATA_W, default 32, SHALL set the instruction word width.
REQ-003 Port clock, input, 1, SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1, SHALL be an asynchronous, active-low reset.
REQ-005 Port stall, input, 1, SHALL be the hazard-unit hold request for the IF/ID outputs.
REQ-006 Port flush, input, 1, SHALL be the squash request for IF/ID contents.
REQ-007 Port redirect, input, 1, SHALL indicate a taken branch or jump.
REQ-008 Port redirect_addr, input, ADDR_W, SHALL be the redirect target address.
REQ-009 Port imem_req, output, 1, SHALL be the instruction-memory request.
REQ-010 Port imem_addr, output, ADDR_W, SHALL be the requested word address.
REQ-011 Port imem_ack, input, 1, SHALL mark imem_data valid for the current request.
REQ-012 Port imem_data, input, DATA_W, SHALL be the returned instruction word.
REQ-013 Port if_instr, output, DATA_W, SHALL be the IF/ID instruction register.
REQ-014 Port if_pc_next, output, ADDR_W, SHALL be the IF/ID register holding fetched address + 1.
REQ-015 Port if_valid, output, 1, SHALL be high when IF/ID holds a real instruction (low = bubble).

Function
REQ-016 Registers: pc (next fetch address), req_addr (address in flight), buf_instr/buf_pcn (hold buffer), IF/ID outputs; all outputs registered.
REQ-017 FSM states: IDLE, REQ, KILL, HOLD.
REQ-018 IDLE: imem_req=0; next cycle unconditionally go REQ with req_addr<=pc.
REQ-019 REQ/KILL: imem_req=1, imem_addr=req_addr held stable until the imem_ack cycle inclusive.
REQ-020 Priority for events in a cycle: redirect > flush > stall > normal load.
REQ-021 REQ, imem_ack, no redirect/flush/stall: IF/ID<=(imem_data, req_addr+1), if_valid<=1, pc and req_addr<=req_addr+1, stay REQ (back-to-back fetch, one instruction per cycle at zero-wait memory).
REQ-022 REQ, imem_ack, stall: buf<=(imem_data, req_addr+1), pc<=req_addr+1, IF/ID unchanged, go HOLD.
REQ-023 REQ, imem_ack, flush (no redirect): data discarded, if_valid<=0, pc and req_addr<=req_addr+1, stay REQ.
REQ-024 REQ, no imem_ack: stall keeps IF/ID; otherwise if_valid<=0 (bubble); flush forces if_valid<=0.
REQ-025 REQ, redirect with imem_ack: data discarded, if_valid<=0, pc and req_addr<=redirect_addr, stay REQ.
REQ-026 REQ, redirect without imem_ack: pc<=redirect_addr, if_valid<=0, go KILL.
REQ-027 KILL: wait for imem_ack, discard its data, then req_addr<=pc and go REQ; a further redirect in KILL updates pc, stays KILL; if_valid<=0 in every KILL cycle unless stall (stall holds IF/ID).
REQ-028 HOLD: imem_req=0; stall high keeps everything; stall low: IF/ID<=buf, if_valid<=1, req_addr<=pc, go REQ.
REQ-029 HOLD, flush: buffer discarded, if_valid<=0, req_addr<=pc, go REQ; HOLD, redirect: buffer discarded, if_valid<=0, pc and req_addr<=redirect_addr, go REQ.
REQ-030 Address arithmetic SHALL be modulo 2^ADDR_W: 2047+1 wraps to 0 with no flag.
REQ-031 No instruction SHALL be fetched twice, skipped, or delivered out of order except as squashed by redirect/flush.

Reset
REQ-032 reset low SHALL immediately force state IDLE, pc=0, req_addr=0, imem_req=0, imem_addr=0, if_instr=0, if_pc_next=0, if_valid=0, buffer cleared.
REQ-033 Reset asserted mid-request SHALL abandon the transaction; an imem_ack after reset release while in IDLE SHALL be ignored.
REQ-034 First request after release SHALL be address 0, issued on the second rising edge after reset deasserts.

Verification
REQ-035 Zero-wait memory, no hazards -> imem_addr 0,1,2,3 on consecutive cycles; if_pc_next 1,2,3,4 with if_valid=1 one cycle behind each ack.
REQ-036 Ack delayed 3 cycles at address 5 -> imem_addr stays 5 for 4 cycles, if_valid=0 bubbles, then if_pc_next=6.
REQ-037 Stall high 2 cycles during ack at address 8 -> IF/ID frozen, imem_req=0 in HOLD, on release if_pc_next=9 then fetch of 9.
REQ-038 Redirect to 0x100 while address 4 pending unacked -> KILL, ack data for 4 never appears on if_instr, next imem_addr=0x100.
REQ-039 pc=2047 with ack -> next imem_addr=0, if_pc_next=0.
REQ-040 reset pulsed low mid-REQ at address 7 -> all outputs 0 immediately; refetch starts at address 0.
